// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 Count/Status/Cause/EPC with exception entry and eret sequencing
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_000F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        exc_req,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  output logic        exc_ack,
  output logic [31:0] exc_addr,
  output logic [31:0] status
);
  typedef enum logic {IDLE, EXC} state_t;
  state_t state, state_nxt;
  logic [31:0] count, cause, epc;
  logic cause_en, accept, eret_go;
  always_comb cause_en = exc_cause == 5'd8  ? status[1] :
                         exc_cause == 5'd9  ? status[2] :
                         exc_cause == 5'd13 ? status[3] : 1'b0;
  assign accept  = state == IDLE && exc_req && status[0] && cause_en;
  assign eret_go = state == IDLE && eret && !accept;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb state_nxt = (state == IDLE && accept) ? EXC : IDLE;
  always_comb begin
    exc_ack  = state == EXC;
    exc_addr = exc_ack ? EXC_VECTOR : epc;
  end
  // Exception entry and eret own Status/Cause/EPC over a same-cycle mtc0
  always_ff @(posedge clk)
    if (rst) begin
      count  <= '0;
      status <= STATUS_RST;
      cause  <= '0;
      epc    <= '0;
    end else begin
      count  <= (mtc0 && addr == 5'd9) ? wdata : count + 32'd1;
      status <= accept ? status << 5 : eret_go ? status >> 5 :
                (mtc0 && addr == 5'd12) ? wdata : status;
      cause  <= accept ? {25'b0, exc_cause, 2'b00} : (mtc0 && addr == 5'd13) ? wdata : cause;
      epc    <= accept ? exc_pc : (mtc0 && addr == 5'd14) ? wdata : epc;
    end
  always_comb rdata = addr == 5'd9  ? count  :
                      addr == 5'd12 ? status :
                      addr == 5'd13 ? cause  :
                      addr == 5'd14 ? epc    : '0;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed scenarios plus randomized run against a register-array reference model
module tb_cp0_regfile;
  logic        clk = 0, rst = 1, mtc0 = 0, exc_req = 0, eret = 0;
  logic [4:0]  addr = 0, exc_cause = 0;
  logic [31:0] wdata = 0, exc_pc = 0;
  logic [31:0] rdata, exc_addr, status;
  logic        exc_ack;
  int n_tests = 0, n_fail = 0;

  cp0_regfile dut (.clk(clk), .rst(rst), .mtc0(mtc0), .addr(addr), .wdata(wdata),
    .rdata(rdata), .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .eret(eret), .exc_ack(exc_ack), .exc_addr(exc_addr), .status(status));

  always #5 clk = ~clk;

  // Reference model: CP0 as a 32-entry array, plus a flag for the ack cycle
  logic [31:0] m_reg [0:31];
  logic        m_exc, m_take;

  function automatic logic cause_on(input logic [4:0] c, input logic [31:0] s);
    if (!(c inside {5'd8, 5'd9, 5'd13})) return 1'b0;
    return s[c == 5'd8 ? 1 : c == 5'd9 ? 2 : 3];
  endfunction

  always_comb m_take = !m_exc && exc_req && m_reg[12][0] && cause_on(exc_cause, m_reg[12]);

  always @(posedge clk)
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] <= (i == 12) ? 32'hF : 32'h0;
      m_exc <= 1'b0;
    end else begin
      m_reg[9] <= m_reg[9] + 1;
      if (mtc0 && addr inside {5'd9, 5'd12, 5'd13, 5'd14}) m_reg[addr] <= wdata;
      if (m_take) begin
        m_reg[14] <= exc_pc;
        m_reg[13] <= 32'(exc_cause) * 4;
        m_reg[12] <= m_reg[12] << 5;
      end else if (eret && !m_exc) m_reg[12] <= m_reg[12] >> 5;
      m_exc <= m_take;
    end

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_tests++; if (status !== 32'hF) begin n_fail++; $display("FAIL reset_status: got %h want 0000000f", status); end
    n_tests++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", exc_ack); end
    n_tests++; if (exc_addr !== 32'h0) begin n_fail++; $display("FAIL reset_exc_addr: got %h want 0", exc_addr); end
    rst = 0; addr = 12; #1;
    n_tests++; if (rdata !== 32'hF) begin n_fail++; $display("FAIL read_status: got %h want 0000000f", rdata); end
    addr = 13; #1;
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL read_cause: got %h want 0", rdata); end
    addr = 14; #1;
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL read_epc: got %h want 0", rdata); end
    addr = 9; #1;
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL read_count0: got %h want 0", rdata); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_tests++; if (rdata !== 32'(i)) begin n_fail++; $display("FAIL count_inc: got %h want %h", rdata, i); end
    end
  endtask

  task automatic test_mtc0();
    mtc0 = 1; addr = 14; wdata = 32'h0040_0010;
    @(negedge clk); mtc0 = 0;
    n_tests++; if (rdata !== 32'h0040_0010) begin n_fail++; $display("FAIL mtc0_epc: got %h want 00400010", rdata); end
    mtc0 = 1; addr = 9; wdata = 32'hFFFF_FFFF;
    @(negedge clk); mtc0 = 0;
    n_tests++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mtc0_count: got %h want ffffffff", rdata); end
    @(negedge clk);
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL count_wrap: got %h want 0", rdata); end
  endtask

  task automatic test_exception();
    exc_req = 1; exc_cause = 8; exc_pc = 32'h0040_0020;
    @(negedge clk); exc_req = 0;
    n_tests++; if (exc_ack !== 1'b1) begin n_fail++; $display("FAIL exc_ack: got %b want 1", exc_ack); end
    n_tests++; if (exc_addr !== 32'h4) begin n_fail++; $display("FAIL exc_vector: got %h want 00000004", exc_addr); end
    n_tests++; if (status !== 32'h1E0) begin n_fail++; $display("FAIL exc_status: got %h want 000001e0", status); end
    addr = 13; #1;
    n_tests++; if (rdata !== 32'h20) begin n_fail++; $display("FAIL exc_cause: got %h want 00000020", rdata); end
    addr = 14; #1;
    n_tests++; if (rdata !== 32'h0040_0020) begin n_fail++; $display("FAIL exc_epc: got %h want 00400020", rdata); end
    @(negedge clk);
    n_tests++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL exc_ack_drop: got %b want 0", exc_ack); end
    n_tests++; if (exc_addr !== 32'h0040_0020) begin n_fail++; $display("FAIL exc_addr_epc: got %h want 00400020", exc_addr); end
  endtask

  task automatic test_masked();
    exc_req = 1; exc_cause = 9;
    repeat (3) begin
      @(negedge clk);
      n_tests++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL masked_ie: got %b want 0", exc_ack); end
    end
    exc_req = 0; eret = 1; #1;
    n_tests++; if (exc_addr !== 32'h0040_0020) begin n_fail++; $display("FAIL eret_addr: got %h want 00400020", exc_addr); end
    @(negedge clk); eret = 0;
    n_tests++; if (status !== 32'hF) begin n_fail++; $display("FAIL eret_status: got %h want 0000000f", status); end
  endtask

  task automatic test_enables();
    mtc0 = 1; addr = 12; wdata = 32'hB;
    @(negedge clk); mtc0 = 0; exc_req = 1; exc_cause = 9;
    @(negedge clk);
    n_tests++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL break_masked: got %b want 0", exc_ack); end
    exc_cause = 13;
    @(negedge clk); exc_req = 0; addr = 13; #1;
    n_tests++; if (exc_ack !== 1'b1) begin n_fail++; $display("FAIL teq_ack: got %b want 1", exc_ack); end
    n_tests++; if (rdata !== 32'h34) begin n_fail++; $display("FAIL teq_cause: got %h want 00000034", rdata); end
    @(negedge clk); eret = 1;
    @(negedge clk); eret = 0;
    n_tests++; if (status !== 32'hB) begin n_fail++; $display("FAIL teq_eret: got %h want 0000000b", status); end
    mtc0 = 1; addr = 12; wdata = 32'hF;
    @(negedge clk); mtc0 = 0;
  endtask

  task automatic test_back_to_back();
    exc_req = 1; exc_cause = 8; exc_pc = 32'h0000_1000;
    @(negedge clk);
    n_tests++; if (exc_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b want 1", exc_ack); end
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_reject: got %b want 0", exc_ack); end
    end
    exc_req = 0; eret = 1;
    @(negedge clk); eret = 0;
    n_tests++; if (status !== 32'hF) begin n_fail++; $display("FAIL b2b_eret: got %h want 0000000f", status); end
  endtask

  task automatic test_precedence();
    exc_req = 1; exc_cause = 8; exc_pc = 32'h0000_2000; eret = 1; mtc0 = 1; addr = 12; wdata = 0;
    @(negedge clk); exc_req = 0; eret = 0; mtc0 = 0;
    n_tests++; if (status !== 32'h1E0) begin n_fail++; $display("FAIL prec_status: got %h want 000001e0", status); end
    n_tests++; if (exc_ack !== 1'b1) begin n_fail++; $display("FAIL prec_ack: got %b want 1", exc_ack); end
    rst = 1;
    @(negedge clk); rst = 0; addr = 9; #1;
    n_tests++; if (exc_ack !== 1'b0) begin n_fail++; $display("FAIL rst_exc_ack: got %b want 0", exc_ack); end
    n_tests++; if (status !== 32'hF) begin n_fail++; $display("FAIL rst_exc_status: got %h want 0000000f", status); end
    n_tests++; if (exc_addr !== 32'h0) begin n_fail++; $display("FAIL rst_exc_epc: got %h want 0", exc_addr); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_exc_count: got %h want 0", rdata); end
    addr = 13; #1;
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_exc_cause: got %h want 0", rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      mtc0 = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: addr = 9; 1: addr = 12; 2: addr = 13; 3: addr = 14;
        default: addr = 5'($urandom_range(0, 31));
      endcase
      wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
      exc_req = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: exc_cause = 8; 1: exc_cause = 9; 2: exc_cause = 13;
        default: exc_cause = 5'($urandom_range(0, 31));
      endcase
      exc_pc = $urandom;
      eret = ($urandom_range(0, 3) == 0);
      #1;
      n_tests++; if (rdata !== m_reg[addr]) begin n_fail++; $display("FAIL rnd_rdata[%0d]: addr %0d got %h want %h", i, addr, rdata, m_reg[addr]); end
      n_tests++; if (exc_ack !== m_exc) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, exc_ack, m_exc); end
      n_tests++; if (exc_addr !== (m_exc ? 32'h4 : m_reg[14])) begin n_fail++; $display("FAIL rnd_exc_addr[%0d]: got %h want %h", i, exc_addr, m_exc ? 32'h4 : m_reg[14]); end
      n_tests++; if (status !== m_reg[12]) begin n_fail++; $display("FAIL rnd_status[%0d]: got %h want %h", i, status, m_reg[12]); end
      @(negedge clk);
    end
    rst = 0; mtc0 = 0; exc_req = 0; eret = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mtc0();
    test_exception();
    test_masked();
    test_enables();
    test_back_to_back();
    test_precedence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the multi-cycle MIPS core, sitting at the receiving end of the CP0 write-data path. It consumes the selected CP0 write word, holds Count/Status/Cause/EPC, and serves `mfc0` reads. It also sequences exception entry (save PC, shift Status, record cause, redirect to the vector) and `eret` return (restore Status, redirect to EPC).

## Interface
- EXC_VECTOR, 32'h0000_0004, PC loaded on exception entry
- STATUS_RST, 32'h0000_000F, Status value after reset (all masks enabled)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mtc0  in  1  write strobe for register `addr`
- addr  in  5  CP0 register number for read and write
- wdata  in  32  write data (output of the CP0 write-data select)
- rdata  out  32  combinational read of register `addr`
- exc_req  in  1  exception request from control unit, level
- exc_cause  in  5  ExcCode: 8 syscall, 9 break, 13 teq
- exc_pc  in  32  PC of faulting instruction
- eret  in  1  exception-return strobe
- exc_ack  out  1  one-cycle pulse: exception accepted, PC must load `exc_addr`
- exc_addr  out  32  EXC_VECTOR while `exc_ack`=1, else EPC
- status  out  32  current Status

## Operation
- Registers: 9 Count, 12 Status, 13 Cause, 14 EPC. Any other `addr` reads 0; writes to it are ignored.
- Status bits: [0] global IE, [1] syscall enable, [2] break enable, [3] teq enable.
- Acceptance: `exc_req` is accepted only if the FSM is in IDLE, Status[0]=1, and the enable bit for `exc_cause` is 1. Unknown codes are never accepted. A rejected request has no effect.
- FSM states:
  - IDLE: on an accepted request, at the edge: EPC<=exc_pc, Cause<={25'b0,exc_cause,2'b00}, Status<=Status<<5, then go to EXC.
  - EXC: `exc_ack`=1 for exactly one cycle, then return to IDLE unconditionally. `exc_req` is ignored in EXC.
- eret: in IDLE, with no accepted exception in the same cycle, Status<=Status>>5 at the edge.
  - `exc_addr` already shows EPC in that cycle.
  - eret while in EXC is ignored.
- mtc0: at the edge, register[addr]<=wdata in either state. Exception entry or eret updates to Status/Cause/EPC in the same cycle take precedence over the mtc0 write.
- Count: increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0. An mtc0 to register 9 wins over the increment.
- Priority per edge: rst > accepted exception > eret > mtc0 > Count increment.
- Reads: `rdata` reflects register contents before the current edge, with no bypass of same-cycle writes.

## Timing
- Reset values: Status=STATUS_RST, Cause=0, EPC=0, Count=0, FSM=IDLE, exc_ack=0, exc_addr=EPC=0, rdata per `addr`.
- Reset applied mid-EXC returns to IDLE with `exc_ack`=0 the next cycle.
- Accepted request at edge N: Status/Cause/EPC update at N; `exc_ack`=1 and exc_addr=EXC_VECTOR during cycle N..N+1; back in IDLE after edge N+1.
- Back-to-back: a request held high across the EXC cycle is re-evaluated in IDLE against the new, shifted Status. With default masks it is therefore rejected.
- eret at edge N: Status restored at N; exc_addr=EPC combinationally during the eret cycle.
- The control unit samples `exc_ack` and loads PC in the same cycle.

## Test plan
- Reset, then addr=12/13/14/9 reads -> 0x0000000F, 0, 0, then Count=1,2,3 on successive cycles.
- mtc0 addr=14 wdata=0x0040_0010 -> next cycle rdata=0x0040_0010. mtc0 addr=9 wdata=0xFFFF_FFFF -> one cycle later Count=0.
- exc_req cause=8, exc_pc=0x0040_0020 -> one cycle later exc_ack=1, exc_addr=0x4, Status=0x1E0, Cause=0x20, EPC=0x0040_0020. The next cycle exc_ack=0 and exc_addr=0x0040_0020.
- After that exception, exc_req cause=9 held 3 cycles -> never acked (Status[0]=0). eret -> Status=0xF.
- mtc0 addr=12 wdata=0xB (break disabled), exc_req cause=9 -> no ack. exc_req cause=13 -> acked, Cause=0x34.
- Same cycle: exc_req (enabled) + eret + mtc0 addr=12 wdata=0 -> exception wins: Status=STATUS_RST<<5, exc_ack next cycle. rst asserted during EXC -> exc_ack=0 and all registers at reset values.
